// File: rtl/serial_adder_ctrl.sv
// ---------------------------------------------------------------------------
// serial_adder_ctrl
//
// Bit-serial adder sequencer. A single full-adder slice (two half adders and
// an OR) is reused for every bit of a WIDTH-bit addition, one bit per clock,
// LSB first. Operands come in over a valid/ready handshake, and the result
// goes out over a second valid/ready handshake.
//
// Optional feature macro: SERIAL_ADD_OVF_EN
//   When defined, the block adds the ovf output and the signed-overflow logic.
//   When undefined, ovf and its logic are absent. All other behaviour and
//   timing are the same in both builds.
//
// Parameters:
//   WIDTH        operand and sum width in bits (>= 1)
//
// Ports:
//   clk          clock, rising edge
//   rst          synchronous active-high reset
//   start_valid  producer offers a, b, cin
//   start_ready  block can accept operands (IDLE only)
//   a, b         addends, sampled on the accept edge
//   cin          carry-in, sampled on the accept edge
//   done_valid   sum/cout (and ovf) are valid
//   done_ready   consumer takes the result
//   sum          result register
//   cout         carry out of bit WIDTH-1
//   busy         high while an operation is in RUN or DONE
//   ovf          signed overflow (SERIAL_ADD_OVF_EN only)
// ---------------------------------------------------------------------------
module serial_adder_ctrl #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start_valid,
    output logic             start_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             done_valid,
    input  logic             done_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             busy
`ifdef SERIAL_ADD_OVF_EN
    ,
    output logic             ovf
`endif
);

    // The bit index always needs at least one bit, even when WIDTH is 1.
    localparam int IDX_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(WIDTH - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t state;
    state_t state_next;

    logic [WIDTH-1:0] a_q;
    logic [WIDTH-1:0] b_q;
    logic [WIDTH-1:0] sum_q;
    logic             cout_q;
    logic             carry;
    logic [IDX_W-1:0] idx;

    logic s1;
    logic c1;
    logic c2;
    logic bit_sum;
    logic carry_next;
    logic last_bit;
    logic accept;
    logic release_done;

    // This is the single shared full-adder slice. It always works on bit idx
    // of the latched operands, together with the running carry.
    always_comb begin
        s1         = a_q[idx] ^ b_q[idx];
        c1         = a_q[idx] & b_q[idx];
        bit_sum    = s1 ^ carry;
        c2         = s1 & carry;
        carry_next = c1 | c2;
    end

    // These are the handshake qualifiers. The state gates both of them, so
    // start_valid has no effect outside IDLE. DONE never starts a new add in
    // the same cycle as it releases the result.
    always_comb begin
        accept       = (state == IDLE) && start_valid;
        release_done = (state == DONE) && done_ready;
        last_bit     = (idx == LAST_IDX);
    end

    // State register. Reset overrides everything, including an add that is
    // still in RUN or waiting in DONE.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic. The block stays in RUN until the slice has processed
    // the MSB. It stays in DONE until the consumer takes the result.
    always_comb begin
        state_next = state;
        case (state)
            IDLE: if (accept)       state_next = RUN;
            RUN:  if (last_bit)     state_next = DONE;
            DONE: if (release_done) state_next = IDLE;
            default:                state_next = IDLE;
        endcase
    end

    // Datapath registers. The operands are copied on accept, so the producer
    // can change a/b/cin right away. In RUN, each edge writes one sum bit in
    // place. The other sum bits keep their old values until the slice reaches
    // them, and cout only changes on the MSB edge.
    always_ff @(posedge clk) begin
        if (rst) begin
            a_q    <= '0;
            b_q    <= '0;
            sum_q  <= '0;
            cout_q <= 1'b0;
            carry  <= 1'b0;
            idx    <= '0;
        end else if (accept) begin
            a_q   <= a;
            b_q   <= b;
            carry <= cin;
            idx   <= '0;
        end else if (state == RUN) begin
            sum_q[idx] <= bit_sum;
            carry      <= carry_next;
            if (last_bit) begin
                cout_q <= carry_next;
            end else begin
                idx <= idx + IDX_W'(1);
            end
        end
    end

`ifdef SERIAL_ADD_OVF_EN
    logic ovf_q;

    // Signed overflow is the carry into the MSB XOR the carry out of the MSB.
    // On the MSB edge, 'carry' still holds the carry into the MSB.
    always_ff @(posedge clk) begin
        if (rst) begin
            ovf_q <= 1'b0;
        end else if ((state == RUN) && last_bit) begin
            ovf_q <= carry ^ carry_next;
        end
    end

    assign ovf = ovf_q;
`endif

    // All outputs come straight from registers or from a decode of the state
    // register. No input feeds an output combinationally.
    assign start_ready = (state == IDLE);
    assign done_valid  = (state == DONE);
    assign busy        = (state != IDLE);
    assign sum         = sum_q;
    assign cout        = cout_q;

endmodule

// File: tb/tb_serial_adder_ctrl.sv
// ---------------------------------------------------------------------------
// tb_serial_adder_ctrl
//
// Self-checking bench for serial_adder_ctrl (WIDTH = 8). A behavioural model
// computes results as plain integer sums and tracks the handshake timing as
// "edges since accept". A compare process checks every DUT output against the
// model on each falling edge. Directed vectors also check literal sums.
// Builds with or without SERIAL_ADD_OVF_EN.
// ---------------------------------------------------------------------------
module tb_serial_adder_ctrl;

    localparam int WIDTH = 8;

    logic             clk;
    logic             rst;
    logic             start_valid;
    logic             start_ready;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             cin;
    logic             done_valid;
    logic             done_ready;
    logic [WIDTH-1:0] sum;
    logic             cout;
    logic             busy;
    logic             ovf;

    int n_checks;
    int n_fail;

    serial_adder_ctrl #(.WIDTH(WIDTH)) dut (
        .clk         (clk),
        .rst         (rst),
        .start_valid (start_valid),
        .start_ready (start_ready),
        .a           (a),
        .b           (b),
        .cin         (cin),
        .done_valid  (done_valid),
        .done_ready  (done_ready),
        .sum         (sum),
        .cout        (cout),
        .busy        (busy)
`ifdef SERIAL_ADD_OVF_EN
        ,
        .ovf         (ovf)
`endif
    );

`ifndef SERIAL_ADD_OVF_EN
    assign ovf = 1'b0;
`endif

    // Free-running clock with a 10-unit period.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // -----------------------------------------------------------------------
    // Behavioural model. It tracks the operation as "idle", "k edges into the
    // add", or "result waiting". The result is simply a + b + cin. During the
    // add, the visible sum is the old sum with its low k bits replaced by the
    // new result.
    // -----------------------------------------------------------------------
    bit               m_init;
    bit               m_active;
    bit               m_waiting;
    int               m_k;
    logic [WIDTH:0]   m_full;
    logic             m_new_ovf;
    logic [WIDTH-1:0] m_base;
    logic [WIDTH-1:0] m_sum;
    logic             m_cout;
    logic             m_ovf;

    initial begin
        m_init    = 1'b0;
        m_active  = 1'b0;
        m_waiting = 1'b0;
        m_k       = 0;
        m_full    = '0;
        m_new_ovf = 1'b0;
        m_base    = '0;
        m_sum     = '0;
        m_cout    = 1'b0;
        m_ovf     = 1'b0;
    end

    // Returns a mask with the low k bits set.
    function automatic logic [WIDTH-1:0] low_mask(input int k);
        logic [WIDTH-1:0] m;
        m = '0;
        for (int i = 0; i < WIDTH; i++) begin
            if (i < k) m[i] = 1'b1;
        end
        return m;
    endfunction

    // Model update on every rising edge. It uses the inputs the bench drove on
    // the preceding falling edge.
    always @(posedge clk) begin
        if (rst) begin
            m_init    = 1'b1;
            m_active  = 1'b0;
            m_waiting = 1'b0;
            m_k       = 0;
            m_sum     = '0;
            m_cout    = 1'b0;
            m_ovf     = 1'b0;
        end else if (m_init) begin
            if (m_active) begin
                m_k   = m_k + 1;
                m_sum = (m_base & ~low_mask(m_k)) | (m_full[WIDTH-1:0] & low_mask(m_k));
                if (m_k == WIDTH) begin
                    m_cout    = m_full[WIDTH];
                    m_ovf     = m_new_ovf;
                    m_active  = 1'b0;
                    m_waiting = 1'b1;
                end
            end else if (m_waiting) begin
                if (done_ready) m_waiting = 1'b0;
            end else if (start_valid) begin
                m_full    = {1'b0, a} + {1'b0, b} + {{WIDTH{1'b0}}, cin};
                m_new_ovf = (a[WIDTH-1] == b[WIDTH-1]) && (m_full[WIDTH-1] != a[WIDTH-1]);
                m_base    = m_sum;
                m_k       = 0;
                m_active  = 1'b1;
            end
        end
    end

    // One comparison: report a FAIL line if the values differ.
    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        n_checks++;
        if (actual !== expected) begin
            n_fail++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, actual, expected, $time);
        end
    endtask

    // Compare process. On each falling edge after the first reset, every
    // output is checked against the model.
    always @(negedge clk) begin
        if (m_init) begin
            checkOutput("start_ready", 32'(start_ready), 32'(!m_active && !m_waiting));
            checkOutput("done_valid",  32'(done_valid),  32'(m_waiting));
            checkOutput("busy",        32'(busy),        32'(m_active || m_waiting));
            checkOutput("sum",         32'(sum),         32'(m_sum));
            checkOutput("cout",        32'(cout),        32'(m_cout));
`ifdef SERIAL_ADD_OVF_EN
            checkOutput("ovf",         32'(ovf),         32'(m_ovf));
`endif
        end
    end

    // Runs one add. Offer the operands, scramble the inputs after the accept,
    // measure the latency to done_valid, and check literal results if given.
    // The result is then held back for 'hold' cycles while start_valid and
    // a/b toggle, and finally released with one handshake.
    task automatic applyStimulus(input logic [WIDTH-1:0] av, input logic [WIDTH-1:0] bv,
                                 input logic cv, input int hold, input bit lit,
                                 input logic [WIDTH-1:0] exp_sum, input logic exp_cout,
                                 input logic exp_ovf);
        int lat;
        @(negedge clk);
        start_valid = 1'b1;
        a           = av;
        b           = bv;
        cin         = cv;
        @(negedge clk);
        start_valid = 1'b0;
        a           = WIDTH'($urandom);
        b           = WIDTH'($urandom);
        cin         = 1'($urandom);
        lat = 0;
        while (!done_valid && lat <= WIDTH + 3) begin
            @(negedge clk);
            lat++;
        end
        checkOutput("latency", 32'(lat), 32'(WIDTH));
        if (lit) begin
            checkOutput("lit_sum",  32'(sum),  32'(exp_sum));
            checkOutput("lit_cout", 32'(cout), 32'(exp_cout));
`ifdef SERIAL_ADD_OVF_EN
            checkOutput("lit_ovf",  32'(ovf),  32'(exp_ovf));
`else
            if (exp_ovf) $display("[TB] note: ovf expectation skipped, overflow port not built");
`endif
        end
        for (int h = 0; h < hold; h++) begin
            start_valid = 1'($urandom);
            a           = WIDTH'($urandom);
            b           = WIDTH'($urandom);
            @(negedge clk);
            checkOutput("hold_start_ready", 32'(start_ready), 32'd0);
        end
        start_valid = 1'b0;
        done_ready  = 1'b1;
        @(negedge clk);
        done_ready = 1'b0;
        checkOutput("release_start_ready", 32'(start_ready), 32'd1);
        checkOutput("release_done_valid",  32'(done_valid),  32'd0);
    endtask

    initial begin
        n_checks    = 0;
        n_fail      = 0;
        rst         = 1'b1;
        start_valid = 1'b0;
        done_ready  = 1'b0;
        a           = '0;
        b           = '0;
        cin         = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b0;

        checkOutput("reset_start_ready", 32'(start_ready), 32'd1);
        checkOutput("reset_busy",        32'(busy),        32'd0);
        checkOutput("reset_sum",         32'(sum),         32'd0);

        $display("[TB] directed vectors");
        applyStimulus(8'h0F, 8'h01, 1'b0, 0, 1'b1, 8'h10, 1'b0, 1'b0);
        applyStimulus(8'hFF, 8'h01, 1'b0, 0, 1'b1, 8'h00, 1'b1, 1'b0);
        applyStimulus(8'h7F, 8'h01, 1'b0, 0, 1'b1, 8'h80, 1'b0, 1'b1);
        applyStimulus(8'h00, 8'h00, 1'b1, 0, 1'b1, 8'h01, 1'b0, 1'b0);
        applyStimulus(8'hAA, 8'h55, 1'b1, 0, 1'b1, 8'h00, 1'b1, 1'b0);

        $display("[TB] backpressure");
        applyStimulus(8'h3C, 8'h44, 1'b0, 5, 1'b1, 8'h80, 1'b0, 1'b1);

        $display("[TB] reset during RUN");
        @(negedge clk);
        start_valid = 1'b1;
        a           = 8'h5A;
        b           = 8'h33;
        cin         = 1'b1;
        @(negedge clk);
        start_valid = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        checkOutput("abort_start_ready", 32'(start_ready), 32'd1);
        checkOutput("abort_busy",        32'(busy),        32'd0);
        checkOutput("abort_done_valid",  32'(done_valid),  32'd0);
        checkOutput("abort_sum",         32'(sum),         32'd0);
        checkOutput("abort_cout",        32'(cout),        32'd0);
        applyStimulus(8'h03, 8'h04, 1'b0, 0, 1'b1, 8'h07, 1'b0, 1'b0);

        $display("[TB] random vectors");
        for (int n = 0; n < 30; n++) begin
            applyStimulus(WIDTH'($urandom), WIDTH'($urandom), 1'($urandom),
                          int'($urandom_range(0, 3)), 1'b0, '0, 1'b0, 1'b0);
        end

        repeat (2) @(negedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/serial_adder_ctrl.md
# serial_adder_ctrl

Bit-serial adder sequencer that reuses one full-adder slice (two half adders plus an OR) for a whole WIDTH-bit addition, processing one bit per clock, LSB first. It sits between an operand producer and a result consumer. Both sides use valid/ready handshakes. This gives the datapath a multi-bit add without instantiating a WIDTH-bit ripple chain.

## Interface
- WIDTH, 8, operand and sum width in bits; must be at least 1.
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  synchronous, active-high reset.
- start_valid  in  1  operand producer has a, b and cin valid.
- start_ready  out  1  block can accept operands; high only in IDLE.
- a  in  WIDTH  addend A; sampled only on the accept edge.
- b  in  WIDTH  addend B; sampled only on the accept edge.
- cin  in  1  carry-in; sampled only on the accept edge.
- done_valid  out  1  sum, cout (and ovf) are valid.
- done_ready  in  1  consumer takes the result.
- sum  out  WIDTH  result register.
- cout  out  1  carry out of bit WIDTH-1.
- busy  out  1  high in RUN and DONE.
- ovf  out  1  signed overflow; present only with SERIAL_ADD_OVF_EN.

Clock and reset: one clock; reset is synchronous and active-high.

## Operation
- The FSM has three states: IDLE, RUN, DONE.
- Internal registers:
  - a_q, b_q: WIDTH bits.
  - carry: 1 bit.
  - idx: clog2(WIDTH) bits, minimum 1.
- IDLE:
  - start_ready = 1.
  - On start_valid && start_ready: latch a_q = a, b_q = b, carry = cin, idx = 0, then go to RUN.
  - sum and cout keep their previous values until the first RUN edge.
- RUN, each edge, using the slice on bit idx:
  - s1 = a_q[idx] ^ b_q[idx]; c1 = a_q[idx] & b_q[idx].
  - sum[idx] = s1 ^ carry; c2 = s1 & carry; carry = c1 | c2.
  - If idx == WIDTH-1: cout = c1 | c2, go to DONE. Otherwise idx = idx + 1.
- DONE:
  - done_valid = 1.
  - On done_valid && done_ready: go to IDLE.
  - sum and cout hold their values until the next accepted operation overwrites them.
- start_valid is ignored outside IDLE.
- a, b and cin may change freely after the accept edge.
- Arithmetic is modulo 2^WIDTH; the full result is {cout, sum}.
- idx never exceeds WIDTH-1; there is no wrap-around.

## Timing
- Reset values:
  - state = IDLE.
  - start_ready = 1, done_valid = 0, busy = 0.
  - sum = 0, cout = 0, ovf = 0.
  - carry = 0, idx = 0.
- Reset takes priority over every other event.
- A reset asserted in RUN or DONE aborts the operation. The partial result is discarded and outputs take their reset values on the next edge.
- Latency: if the accept happens at edge E0, done_valid first reads high after edge E0+WIDTH.
  - For WIDTH = 1, done_valid is high the cycle after accept.
- With done_ready held high, the done handshake completes at edge E0+WIDTH+1. start_ready is high after that edge.
- The minimum initiation interval is WIDTH+2 cycles per add.
- There is no same-cycle done-to-start bypass. start_ready is low in DONE even when done_ready is high.
- Backpressure: done_valid, sum, cout and ovf stay stable while done_ready is low, for any number of cycles.
- All outputs are registered; no input-to-output combinational path exists.

## Configuration
- SERIAL_ADD_OVF_EN defined:
  - Port ovf exists.
  - On the RUN edge with idx == WIDTH-1, ovf = carry_in_to_msb ^ (c1 | c2). carry_in_to_msb is the carry value before that edge.
  - ovf is reset to 0 and is valid together with done_valid.
- SERIAL_ADD_OVF_EN undefined:
  - Port ovf is absent and no overflow logic is generated.
  - All other behaviour and timing are identical.

## Test plan
- WIDTH = 8, a = 0x0F, b = 0x01, cin = 0, accept at E0:
  - done_valid first high after E0+8.
  - sum = 0x10, cout = 0, ovf = 0.
- a = 0xFF, b = 0x01, cin = 0:
  - sum = 0x00, cout = 1, ovf = 0.
- a = 0x7F, b = 0x01, cin = 0 (macro defined):
  - sum = 0x80, cout = 0, ovf = 1.
- Carry-in: a = 0x00, b = 0x00, cin = 1:
  - sum = 0x01, cout = 0.
  - Carry-in case, variant: a = 0xAA, b = 0x55, cin = 1 gives sum = 0x00, cout = 1.
- Backpressure: hold done_ready = 0 for 5 cycles after done_valid rises, toggle start_valid and change a/b:
  - sum, cout, done_valid remain stable; start_ready = 0; no new accept.
  - After done_ready = 1, exactly one handshake occurs and start_ready = 1 on the next cycle.
- Reset mid-RUN: assert rst for one cycle 3 edges after accept:
  - The next cycle shows start_ready = 1, busy = 0, done_valid = 0, sum = 0x00, cout = 0.
  - A fresh add 0x03 + 0x04 then yields 0x07 with the full 8-cycle latency.
